// File: rtl/change_dispenser_pkg.sv
// Shared vending types: coin values, refill select encoding, payout FSM states.
// Used by change_dispenser and its interface.
package vend_pkg;

    localparam logic [6:0] COIN_Q     = 7'd25;
    localparam logic [6:0] COIN_D     = 7'd10;
    localparam logic [6:0] COIN_N     = 7'd5;
    localparam logic [6:0] MAX_CHANGE = 7'd100;

    typedef enum logic [1:0] {
        SEL_Q    = 2'b00,
        SEL_D    = 2'b01,
        SEL_N    = 2'b10,
        SEL_NONE = 2'b11
    } refill_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_GAP,
        ST_FINISH
    } state_e;

    // Add with 5-bit headroom, then clip to the inventory limit.
    function automatic logic [3:0] sat_add(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [3:0] lim
    );
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[3:0];
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request / eject / refill / inventory bundle of change_dispenser.
// Carries the tally signals only when CHANGE_TALLY_EN is defined.
interface change_dispenser_if;

    logic       chg_valid;
    logic [6:0] chg_amount;
    logic       chg_ready;
    logic       eject_q;
    logic       eject_d;
    logic       eject_n;
    logic       busy;
    logic       done;
    logic [6:0] shortfall;
    logic       short_err;
    logic       refill_valid;
    logic [1:0] refill_sel;
    logic [3:0] refill_qty;
    logic [3:0] inv_q;
    logic [3:0] inv_d;
    logic [3:0] inv_n;
`ifdef CHANGE_TALLY_EN
    logic       tally_clr;
    logic [7:0] tally_q;
    logic [7:0] tally_d;
    logic [7:0] tally_n;

    modport master (
        output chg_valid, chg_amount, refill_valid, refill_sel, refill_qty,
        output tally_clr,
        input  chg_ready, eject_q, eject_d, eject_n, busy, done,
        input  shortfall, short_err, inv_q, inv_d, inv_n,
        input  tally_q, tally_d, tally_n
    );

    modport slave (
        input  chg_valid, chg_amount, refill_valid, refill_sel, refill_qty,
        input  tally_clr,
        output chg_ready, eject_q, eject_d, eject_n, busy, done,
        output shortfall, short_err, inv_q, inv_d, inv_n,
        output tally_q, tally_d, tally_n
    );
`else
    modport master (
        output chg_valid, chg_amount, refill_valid, refill_sel, refill_qty,
        input  chg_ready, eject_q, eject_d, eject_n, busy, done,
        input  shortfall, short_err, inv_q, inv_d, inv_n
    );

    modport slave (
        input  chg_valid, chg_amount, refill_valid, refill_sel, refill_qty,
        output chg_ready, eject_q, eject_d, eject_n, busy, done,
        output shortfall, short_err, inv_q, inv_d, inv_n
    );
`endif

endinterface

// File: rtl/change_dispenser_timer.sv
// pulse_timer: loadable down-counter, active while its count is nonzero.
// Times both the eject pulse and the inter-coin gap.
module pulse_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_active
);

    logic [W-1:0] r_count;

    // Load overrides; otherwise count down to zero and hold.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_active = (r_count != '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout (Q, D, N) with per-denomination inventory and refill.
// Optional per-coin tally counters under CHANGE_TALLY_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int MAX_COINS    = 15,
    parameter int INIT_Q       = 4,
    parameter int INIT_D       = 5,
    parameter int INIT_N       = 6
) (
    input logic              clock,
    input logic              rst_n,
    change_dispenser_if.slave bus
);

    // Timer is loaded with N-1 so the phase lasts N cycles (count N-1 .. 0).
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] INV_MAX  = 4'(MAX_COINS);

    state_e     r_state;
    logic [6:0] r_rem;
    logic [3:0] r_inv_q;
    logic [3:0] r_inv_d;
    logic [3:0] r_inv_n;
    logic       r_eject_q;
    logic       r_eject_d;
    logic       r_eject_n;
    logic       r_busy;
    logic       r_done;
    logic       r_ready;
    logic [6:0] r_shortfall;
    logic       r_short_err;

    logic       w_accept;
    logic       w_pick_q;
    logic       w_pick_d;
    logic       w_pick_n;
    logic       w_pick;
    logic       w_active;
    logic       w_load;
    logic [7:0] w_value;

    assign w_accept = (r_state == ST_IDLE) && bus.chg_valid;

    assign w_pick_q = (r_rem >= COIN_Q) && (r_inv_q != 4'd0);
    assign w_pick_d = !w_pick_q && (r_rem >= COIN_D) && (r_inv_d != 4'd0);
    assign w_pick_n = !w_pick_q && !w_pick_d
                      && (r_rem >= COIN_N) && (r_inv_n != 4'd0);
    assign w_pick   = w_pick_q || w_pick_d || w_pick_n;

    assign w_load  = ((r_state == ST_SELECT) && w_pick)
                     || ((r_state == ST_PULSE) && !w_active);
    assign w_value = (r_state == ST_SELECT) ? PULSE_LD : GAP_LD;

    pulse_timer #(.W(8)) u_timer (
        .clock    (clock),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_value  (w_value),
        .o_active (w_active)
    );

    // Payout FSM with registered outputs, inventory and refill handling.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rem       <= 7'd0;
            r_inv_q     <= 4'(INIT_Q);
            r_inv_d     <= 4'(INIT_D);
            r_inv_n     <= 4'(INIT_N);
            r_eject_q   <= 1'b0;
            r_eject_d   <= 1'b0;
            r_eject_n   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
            r_shortfall <= 7'd0;
            r_short_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rem       <= (bus.chg_amount > MAX_CHANGE)
                                       ? MAX_CHANGE : bus.chg_amount;
                        r_shortfall <= 7'd0;
                        r_short_err <= 1'b0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SELECT;
                    end else if (bus.refill_valid) begin
                        unique case (refill_sel_e'(bus.refill_sel))
                            SEL_Q:    r_inv_q <= sat_add(r_inv_q, bus.refill_qty, INV_MAX);
                            SEL_D:    r_inv_d <= sat_add(r_inv_d, bus.refill_qty, INV_MAX);
                            SEL_N:    r_inv_n <= sat_add(r_inv_n, bus.refill_qty, INV_MAX);
                            SEL_NONE: ;
                            default:  ;
                        endcase
                    end
                end
                ST_SELECT: begin
                    unique case (1'b1)
                        w_pick_q: begin
                            r_inv_q   <= r_inv_q - 4'd1;
                            r_rem     <= r_rem - COIN_Q;
                            r_eject_q <= 1'b1;
                            r_state   <= ST_PULSE;
                        end
                        w_pick_d: begin
                            r_inv_d   <= r_inv_d - 4'd1;
                            r_rem     <= r_rem - COIN_D;
                            r_eject_d <= 1'b1;
                            r_state   <= ST_PULSE;
                        end
                        w_pick_n: begin
                            r_inv_n   <= r_inv_n - 4'd1;
                            r_rem     <= r_rem - COIN_N;
                            r_eject_n <= 1'b1;
                            r_state   <= ST_PULSE;
                        end
                        default: begin
                            r_shortfall <= r_rem;
                            r_short_err <= (r_rem >= COIN_N);
                            r_done      <= 1'b1;
                            r_state     <= ST_FINISH;
                        end
                    endcase
                end
                ST_PULSE: begin
                    if (!w_active) begin
                        r_eject_q <= 1'b0;
                        r_eject_d <= 1'b0;
                        r_eject_n <= 1'b0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!w_active) begin
                        r_state <= ST_SELECT;
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CHANGE_TALLY_EN
    logic [7:0] r_tally_q;
    logic [7:0] r_tally_d;
    logic [7:0] r_tally_n;
    logic       w_sel;

    assign w_sel = (r_state == ST_SELECT);

    // Saturating count of coins chosen since reset; clear has priority.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_tally_q <= 8'd0;
            r_tally_d <= 8'd0;
            r_tally_n <= 8'd0;
        end else if (bus.tally_clr) begin
            r_tally_q <= 8'd0;
            r_tally_d <= 8'd0;
            r_tally_n <= 8'd0;
        end else begin
            if (w_sel && w_pick_q && r_tally_q != 8'hFF) r_tally_q <= r_tally_q + 8'd1;
            if (w_sel && w_pick_d && r_tally_d != 8'hFF) r_tally_d <= r_tally_d + 8'd1;
            if (w_sel && w_pick_n && r_tally_n != 8'hFF) r_tally_n <= r_tally_n + 8'd1;
        end
    end

    assign bus.tally_q = r_tally_q;
    assign bus.tally_d = r_tally_d;
    assign bus.tally_n = r_tally_n;
`endif

    assign bus.chg_ready = r_ready;
    assign bus.eject_q   = r_eject_q;
    assign bus.eject_d   = r_eject_d;
    assign bus.eject_n   = r_eject_n;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.shortfall = r_shortfall;
    assign bus.short_err = r_short_err;
    assign bus.inv_q     = r_inv_q;
    assign bus.inv_d     = r_inv_d;
    assign bus.inv_n     = r_inv_n;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random requests
// checked against a greedy-payout inventory model.
module tb_change_dispenser;

    localparam int P    = 4;
    localparam int G    = 2;
    localparam int MAXC = 15;
    localparam int IQ   = 4;
    localparam int ID   = 5;
    localparam int IN   = 6;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    change_dispenser_if bus();

    change_dispenser #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .MAX_COINS    (MAXC),
        .INIT_Q       (IQ),
        .INIT_D       (ID),
        .INIT_N       (IN)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int mq, md, mn;
    int done_cnt = 0;

    always @(negedge clock) if (bus.done === 1'b1) done_cnt++;

    task automatic model_init();
        mq = IQ; md = ID; mn = IN;
    endtask

    task automatic check_inv(input string nm);
        n_cmp++;
        if (int'(bus.inv_q) !== mq || int'(bus.inv_d) !== md || int'(bus.inv_n) !== mn) begin
            n_bad++;
            $display("FAIL %s inv: got q%0d d%0d n%0d want q%0d d%0d n%0d",
                     nm, bus.inv_q, bus.inv_d, bus.inv_n, mq, md, mn);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_init();
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        @(negedge clock);
        while (bus.chg_ready !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        n_cmp++;
        if (bus.chg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_timeout: got %b want 1", nm, bus.chg_ready);
        end
    endtask

    task automatic do_refill(input int sel, input int qty, input string nm);
        wait_ready(nm);
        bus.refill_valid = 1'b1;
        bus.refill_sel   = sel[1:0];
        bus.refill_qty   = qty[3:0];
        @(posedge clock);
        #1;
        bus.refill_valid = 1'b0;
        case (sel)
            0: mq = (mq + qty > MAXC) ? MAXC : mq + qty;
            1: md = (md + qty > MAXC) ? MAXC : md + qty;
            2: mn = (mn + qty > MAXC) ? MAXC : mn + qty;
            default: ;
        endcase
        @(negedge clock);
        check_inv(nm);
    endtask

    // One request: model predicts the coin list, bench observes pulses.
    task automatic run_req(input int amt, input bit rf_busy, input bit rf_acc, input string nm);
        int rem;
        int exp_seq[$];
        int got[$];
        int widths[$];
        int gaps[$];
        int cyc, first, cur, w, low, c, k, sf;
        bit multi, done_seen, busy1, err, bad;
        string s;
        rem = (amt > 100) ? 100 : amt;
        forever begin
            if (rem >= 25 && mq > 0) begin exp_seq.push_back(1); rem -= 25; mq--; end
            else if (rem >= 10 && md > 0) begin exp_seq.push_back(2); rem -= 10; md--; end
            else if (rem >= 5 && mn > 0) begin exp_seq.push_back(3); rem -= 5; mn--; end
            else break;
        end
        wait_ready(nm);
        bus.chg_valid  = 1'b1;
        bus.chg_amount = amt[6:0];
        if (rf_acc) begin
            bus.refill_valid = 1'b1;
            bus.refill_sel   = 2'b01;
            bus.refill_qty   = 4'd5;
        end
        @(posedge clock);
        #1;
        bus.chg_valid    = 1'b0;
        bus.refill_valid = rf_busy;
        bus.refill_sel   = 2'b01;
        bus.refill_qty   = 4'd3;
        cyc = 0; first = -1; cur = 0; w = 0; low = 0;
        multi = 0; done_seen = 0; busy1 = 0; sf = 0; err = 0;
        while (!done_seen && cyc < 600) begin
            @(negedge clock);
            cyc++;
            k = int'(bus.eject_q) + int'(bus.eject_d) + int'(bus.eject_n);
            if (k > 1) multi = 1;
            c = bus.eject_q ? 1 : bus.eject_d ? 2 : bus.eject_n ? 3 : 0;
            if (cyc == 1) busy1 = bus.busy;
            if (c != 0) begin
                if (c != cur) begin
                    if (cur != 0) widths.push_back(w);
                    got.push_back(c);
                    if (first < 0) first = cyc;
                    else if (cur == 0) gaps.push_back(low);
                    w = 1;
                end else begin
                    w++;
                end
                low = 0;
            end else begin
                if (cur != 0) widths.push_back(w);
                low++;
            end
            cur = c;
            if (bus.done === 1'b1) begin
                done_seen = 1;
                sf  = int'(bus.shortfall);
                err = bus.short_err;
            end
        end
        bus.refill_valid = 1'b0;
        n_cmp++;
        if (!done_seen) begin
            n_bad++;
            $display("FAIL %s done_timeout: got 0 want 1 within 600 cycles", nm);
        end
        n_cmp++;
        bad = (got.size() != exp_seq.size());
        foreach (exp_seq[i]) if (!bad && got[i] != exp_seq[i]) bad = 1;
        if (bad) begin
            n_bad++;
            s = "";
            foreach (got[i]) s = {s, $sformatf("%0d", got[i])};
            s = {s, " want "};
            foreach (exp_seq[i]) s = {s, $sformatf("%0d", exp_seq[i])};
            $display("FAIL %s coin_seq(1=Q 2=D 3=N): got %s", nm, s);
        end
        n_cmp++;
        bad = 0;
        foreach (widths[i]) if (widths[i] != P) bad = 1;
        foreach (gaps[i]) if (gaps[i] != G + 1) bad = 1;
        if (bad || multi) begin
            n_bad++;
            $display("FAIL %s pulse_shape: got multi=%0d widths=%p gaps=%p want width %0d low %0d",
                     nm, multi, widths, gaps, P, G + 1);
        end
        if (exp_seq.size() > 0) begin
            n_cmp++;
            if (first != 2) begin
                n_bad++;
                $display("FAIL %s latency: got %0d want 2", nm, first);
            end
        end
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy: got %b want 1", nm, busy1);
        end
        n_cmp++;
        if (sf != rem || err != (rem >= 5)) begin
            n_bad++;
            $display("FAIL %s shortfall: got %0d/%0d want %0d/%0d", nm, sf, err, rem, rem >= 5);
        end
        check_inv(nm);
        @(negedge clock);
        n_cmp++;
        if (bus.chg_ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_done: got ready=%b done=%b busy=%b want 1 0 0",
                     nm, bus.chg_ready, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (bus.chg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0
            || bus.eject_q !== 1'b0 || bus.eject_d !== 1'b0 || bus.eject_n !== 1'b0
            || bus.shortfall !== 7'd0 || bus.short_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b ej=%b%b%b sf=%0d err=%b want 1 0 0 000 0 0",
                     bus.chg_ready, bus.busy, bus.done, bus.eject_q, bus.eject_d,
                     bus.eject_n, bus.shortfall, bus.short_err);
        end
        model_init();
        check_inv("reset");
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_req(65, 0, 0, "req65");
    endtask

    task automatic test_clamp();
        do_reset();
        run_req(120, 0, 0, "req120");
    endtask

    task automatic test_refill();
        do_refill(1, 15, "refill_sat");
        do_refill(3, 5, "refill_sel11");
        do_refill(2, 4, "refill_n");
        run_req(100, 1, 0, "refill_busy");
    endtask

    task automatic test_exhaust();
        run_req(40, 0, 0, "req40a");
        run_req(40, 0, 0, "req40_dn");
        run_req(20, 0, 0, "req20");
        run_req(15, 0, 0, "req15_empty");
    endtask

    task automatic test_edges();
        do_refill(2, 15, "refill_n15");
        run_req(3, 0, 0, "req3");
        run_req(0, 0, 0, "req0");
        run_req(10, 0, 1, "accept_vs_refill");
    endtask

    task automatic test_mid_reset();
        int t = 0;
        int seen = 0;
        int dc;
        bit prev = 0;
        do_reset();
        wait_ready("midrst");
        bus.chg_valid  = 1'b1;
        bus.chg_amount = 7'd50;
        @(posedge clock);
        #1;
        bus.chg_valid = 1'b0;
        while (seen < 2 && t < 100) begin
            @(negedge clock);
            t++;
            if (bus.eject_q === 1'b1 && !prev) seen++;
            prev = bus.eject_q;
        end
        n_cmp++;
        if (seen < 2) begin
            n_bad++;
            $display("FAIL midrst_second_pulse: got %0d pulses want 2", seen);
        end
        #2;
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        model_init();
        n_cmp++;
        if (bus.eject_q !== 1'b0 || bus.eject_d !== 1'b0 || bus.eject_n !== 1'b0
            || bus.chg_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got ej=%b%b%b rdy=%b busy=%b want 000 1 0",
                     bus.eject_q, bus.eject_d, bus.eject_n, bus.chg_ready, bus.busy);
        end
        check_inv("midrst");
        @(negedge clock);
        rst_n = 1'b1;
        repeat (20) @(negedge clock);
        n_cmp++;
        if (done_cnt != dc) begin
            n_bad++;
            $display("FAIL midrst_no_done: got %0d done pulses want 0", done_cnt - dc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            if ($urandom % 3 == 0)
                do_refill(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), "rand_refill");
            run_req(int'($urandom_range(0, 127)), ($urandom % 4) == 0,
                    ($urandom % 5) == 0, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        bus.chg_valid    = 1'b0;
        bus.chg_amount   = 7'd0;
        bus.refill_valid = 1'b0;
        bus.refill_sel   = 2'b00;
        bus.refill_qty   = 4'd0;
`ifdef CHANGE_TALLY_EN
        bus.tally_clr    = 1'b0;
`endif
        test_reset();
        test_basic();
        test_clamp();
        test_refill();
        test_exhaust();
        test_edges();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin-output side of the vending controller: the controller accepts coins and computes a change amount; this block pays that amount out as physical coin-eject pulses.
- Takes a change amount in cents via a valid/ready handshake and pays it out greedily (quarters, then dimes, then nickels), one pulse per coin.
- Tracks an on-board coin inventory per denomination, refillable in service mode.
- Reports any amount it could not pay.

Parameters:
- PULSE_CYCLES, 4, width of each eject pulse in clock cycles (>=1).
- GAP_CYCLES, 2, idle cycles between consecutive eject pulses (>=1).
- MAX_COINS, 15, inventory saturation limit per denomination (fits 4 bits).
- INIT_Q / INIT_D / INIT_N, 4 / 5 / 6, reset inventory of quarters / dimes / nickels.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- chg_valid  in  1  change request present.
- chg_amount  in  7  change in cents; values >100 are clamped to 100.
- chg_ready  out  1  block idle and able to accept a request.
- eject_q / eject_d / eject_n  out  1 each  coin-eject pulses (25c / 10c / 5c).
- busy  out  1  payout in progress.
- done  out  1  one-cycle pulse at end of payout.
- shortfall  out  7  unpaid residual cents of the last payout, held until the next accept.
- short_err  out  1  asserted with done when shortfall >= 5; held until the next accept.
- refill_valid  in  1  service refill strobe.
- refill_sel  in  2  00=quarter, 01=dime, 10=nickel, 11=ignored.
- refill_qty  in  4  coins to add.
- inv_q / inv_d / inv_n  out  4 each  current inventory.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All eject_*, busy, done, short_err = 0; shortfall = 0; chg_ready = 1.
  - inv_* = INIT_*; internal remaining register = 0.
- Handshake:
  - Accept occurs when chg_valid && chg_ready on a rising edge.
  - On accept: remaining <= min(chg_amount, 100); shortfall and short_err clear; chg_ready drops the next cycle.
  - chg_amount is sampled only at accept.
- FSM states: IDLE, SELECT, PULSE, GAP, FINISH.
  - IDLE -> SELECT on accept.
  - SELECT, evaluated in one cycle:
    - if remaining >= 25 and inv_q > 0: select Q;
    - else if remaining >= 10 and inv_d > 0: select D;
    - else if remaining >= 5 and inv_n > 0: select N;
    - else go to FINISH.
  - On a selection: decrement that inventory by 1 and subtract the coin value from remaining (both in the SELECT cycle), then go to PULSE.
  - PULSE: the selected eject_* output is high for exactly PULSE_CYCLES cycles, then go to GAP.
  - GAP: all eject outputs low for GAP_CYCLES cycles, then return to SELECT.
  - FINISH: shortfall <= remaining; short_err <= (remaining >= 5); done = 1 for one cycle; then IDLE, with chg_ready = 1 in the following cycle.
- Ejection rules:
  - At most one eject output is high at any time.
  - busy = 1 from the cycle after accept through FINISH.
- Latency: accept -> first eject rising edge = 2 cycles (SELECT, then PULSE registered).
- A zero-amount request goes SELECT -> FINISH with done, shortfall 0, and no eject pulses.
- A non-multiple-of-5 residual (e.g. 3c) ends in FINISH with shortfall = 3 and short_err = 0.
- Refill:
  - Honoured only in IDLE with no accept in the same cycle; ignored otherwise (no queuing).
  - inv <= min(inv + refill_qty, MAX_COINS), computed at 5-bit width before saturation.
  - refill_sel = 11 has no effect.
- Simultaneous accept and refill in IDLE: accept wins and the refill is dropped.
- Inventory never underflows, because selection requires inv > 0.
- Reset mid-payout aborts immediately: pulses are cut, inventory returns to INIT_*, and no done pulse is produced.

Optional Feature:
- Macro: CHANGE_TALLY_EN.
- Defined:
  - Adds outputs tally_q, tally_d, tally_n (8 bits each), counting coins ejected since reset and saturating at 255.
  - Adds input tally_clr, which zeroes all three counters synchronously.
  - Each counter increments in the SELECT cycle that chooses its coin.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package vend_pkg holds:
  - coin value constants COIN_Q=25, COIN_D=10, COIN_N=5;
  - MAX_CHANGE=100;
  - the refill_sel encoding enum;
  - the FSM state typedef.
- One sub-module, pulse_timer: loadable down-counter that asserts while its count is nonzero; reused for both the PULSE and GAP phases.

Test Plan:
- Reset, then request 65: expect pulse sequence Q, Q, D, N; inv_q=2, inv_d=4, inv_n=5; done with shortfall 0, short_err 0.
- Request 120: clamped to 100, pays Q×4; inv_q=0.
- Set inv_q=0 and inv_d=1 (via the reset variant INIT_Q=0, INIT_D=1), request 40: pays D, N×6; done with shortfall 0.
- Set inv_n=0 with all other coins exhausted, request 15: no pulses; done with shortfall 15, short_err 1.
- Refill sel=01, qty=15 while inv_d=5: inv_d saturates at 15; the same refill asserted while busy leaves inv_d unchanged.
- Reset asserted during the second PULSE of a 50c payout: eject outputs drop asynchronously, inventory returns to INIT_*, chg_ready=1, no done pulse.
